match_controller: RTL and testbench
===================================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5, goals needed to win (1..9).
REQ-002 SHALL have parameter KICKOFF_FRAMES, default 120, frame ticks spent in KICKOFF.
REQ-003 SHALL have parameter GOAL_FRAMES, default 180, frame ticks spent in GOAL celebration.
REQ-004 SHALL have parameter FRAMES_PER_SEC, default 60, frame ticks per match-clock second.
REQ-005 SHALL have parameter MATCH_SECONDS, default 90, match length in seconds (1..255).
REQ-006 SHALL have ports: clk  in  1  system clock; reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: frame_tick  in  1  one-cycle pulse per video frame; start_btn  in  1  debounced one-cycle start pulse; pause_btn  in  1  debounced one-cycle pause pulse.
REQ-008 SHALL have ports: ball_in_goal1  in  1  level, ball inside player 2's goal (scores for player 1); ball_in_goal2  in  1  level, ball inside player 1's goal (scores for player 2).
REQ-009 SHALL have ports: goal_player1  out  1  one-cycle pulse to the scoreboard; goal_player2  out  1  likewise; clear_scores  out  1  one-cycle pulse resetting the scoreboard.
REQ-010 SHALL have ports: reset_positions  out  1  one-cycle pulse to respawn players/ball; freeze  out  1  physics hold; state  out  3  current state; winner  out  2  00 none, 01 p1, 10 p2, 11 draw; time_left  out  8  remaining seconds.

Function
REQ-011 SHALL implement states IDLE=0, KICKOFF=1, PLAY=2, GOAL=3, PAUSED=4, GAME_OVER=5 on output state.
REQ-012 SHALL drive freeze=1 in every state except PLAY.
REQ-013 SHALL, in IDLE or GAME_OVER, on start_btn, pulse clear_scores and reset_positions in the following cycle, zero its internal goal counts, load time_left=MATCH_SECONDS, clear winner, and enter KICKOFF.
REQ-014 SHALL stay in KICKOFF for KICKOFF_FRAMES frame_tick pulses, then enter PLAY.
REQ-015 SHALL register both ball_in_goal inputs and detect a goal on a rising edge seen only in PLAY; levels held across state changes SHALL NOT retrigger.
REQ-016 SHALL, on a goal edge, assert the matching goal_playerN for exactly one cycle the cycle after the edge, increment its internal count (4-bit, saturating at 9), and enter GOAL.
REQ-017 SHALL, on simultaneous rising edges, credit player 1 only.
REQ-018 SHALL stay in GOAL for GOAL_FRAMES frame ticks; then if either count equals WIN_SCORE, enter GAME_OVER with winner set, else pulse reset_positions and enter KICKOFF.
REQ-019 SHALL toggle between PLAY and PAUSED on pause_btn; pause_btn SHALL be ignored in other states; PAUSED SHALL hold all counters.
REQ-020 SHALL ignore start_btn outside IDLE and GAME_OVER.
REQ-021 SHALL count frame ticks only in the states that use them, clearing the frame counter on every state entry.

Reset
REQ-022 SHALL, while reset_n=0, force state=IDLE, freeze=1, goal_player1=goal_player2=clear_scores=reset_positions=0, winner=00, time_left=0, and all counters and edge registers to 0.
REQ-023 SHALL, on reset assertion mid-match, abandon the match immediately; the first start_btn after release SHALL begin a fresh match per REQ-013.

Configuration
REQ-024 SHALL support macro MATCH_TIMER_EN: when defined, time_left SHALL decrement once per FRAMES_PER_SEC frame ticks spent in PLAY only, and reaching 0 in PLAY SHALL enter GAME_OVER in the next cycle with winner 01/10 by higher count, or 11 if equal.
REQ-025 SHALL, without MATCH_TIMER_EN, tie time_left to 0, omit the seconds counter, and end matches only via WIN_SCORE.

Verification
REQ-026 SHALL cover: reset, start_btn, 120 ticks -> clear_scores and reset_positions one-cycle pulses, state 1 then 2, freeze drops to 0.
REQ-027 SHALL cover: in PLAY, ball_in_goal1 rises and holds 500 cycles -> exactly one goal_player1 pulse, state 3, and after 180 ticks state 1 with a reset_positions pulse.
REQ-028 SHALL cover: both goal inputs rise in the same cycle -> goal_player1 pulses, goal_player2 stays 0.
REQ-029 SHALL cover: WIN_SCORE=2, two p2 goals -> after the second GOAL phase, state 5 and winner=10; a further start_btn -> clear_scores pulse and state 1.
REQ-030 SHALL cover: with MATCH_TIMER_EN, MATCH_SECONDS=2, FRAMES_PER_SEC=4, pause for 20 ticks mid-match -> time_left frozen while paused; at 0 with 0-0 score, state 5 and winner=11.
REQ-031 SHALL cover: reset_n pulsed low during GOAL -> all outputs at reset values within the same cycle, state 0 after release.

Source files
------------

// File: rtl/match_controller.sv
// Match sequencing for a two-player ball game: kickoff, play, goal celebration, pause, game over.
// Optional match clock is enabled by defining MATCH_TIMER_EN; without it matches end only on WIN_SCORE.
module match_controller #(
    parameter int WIN_SCORE      = 5,
    parameter int KICKOFF_FRAMES = 120,
    parameter int GOAL_FRAMES    = 180,
    parameter int FRAMES_PER_SEC = 60,
    parameter int MATCH_SECONDS  = 90
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       ball_in_goal1,
    input  logic       ball_in_goal2,
    output logic       goal_player1,
    output logic       goal_player2,
    output logic       clear_scores,
    output logic       reset_positions,
    output logic       freeze,
    output logic [2:0] state,
    output logic [1:0] winner,
    output logic [7:0] time_left
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_KICKOFF   = 3'd1,
        S_PLAY      = 3'd2,
        S_GOAL      = 3'd3,
        S_PAUSED    = 3'd4,
        S_GAME_OVER = 3'd5
    } state_e;

    localparam logic [15:0] KICK_LAST = 16'(KICKOFF_FRAMES - 1);
    localparam logic [15:0] GOAL_LAST = 16'(GOAL_FRAMES - 1);
    localparam logic [3:0]  WIN       = 4'(WIN_SCORE);

    if (WIN_SCORE < 1 || WIN_SCORE > 9) begin : g_bad_win
        $error("match_controller: WIN_SCORE must be 1..9");
    end
    if (MATCH_SECONDS < 1 || MATCH_SECONDS > 255) begin : g_bad_secs
        $error("match_controller: MATCH_SECONDS must be 1..255");
    end
    if (KICKOFF_FRAMES < 1 || GOAL_FRAMES < 1 || FRAMES_PER_SEC < 1) begin : g_bad_frames
        $error("match_controller: frame counts must be at least 1");
    end

    state_e      state_q, state_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]  score1_q, score1_d;
    logic [3:0]  score2_q, score2_d;
    logic [1:0]  winner_q, winner_d;
    logic        ball1_q, ball2_q;
    logic        gp1_q, gp1_d;
    logic        gp2_q, gp2_d;
    logic        clr_q, clr_d;
    logic        rp_q, rp_d;
    logic        rise1, rise2;

`ifdef MATCH_TIMER_EN
    localparam logic [15:0] SEC_LAST = 16'(FRAMES_PER_SEC - 1);
    logic [7:0]  time_left_q, time_left_d;
    logic [15:0] sec_cnt_q, sec_cnt_d;
`endif

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= 4'd9) ? v : v + 4'd1;
    endfunction

    // Edges are taken against the previous cycle's level, so a ball resting in a goal never rescores.
    assign rise1 = ball_in_goal1 & ~ball1_q;
    assign rise2 = ball_in_goal2 & ~ball2_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            score1_q    <= '0;
            score2_q    <= '0;
            winner_q    <= 2'b00;
            ball1_q     <= 1'b0;
            ball2_q     <= 1'b0;
            gp1_q       <= 1'b0;
            gp2_q       <= 1'b0;
            clr_q       <= 1'b0;
            rp_q        <= 1'b0;
`ifdef MATCH_TIMER_EN
            time_left_q <= '0;
            sec_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            winner_q    <= winner_d;
            ball1_q     <= ball_in_goal1;
            ball2_q     <= ball_in_goal2;
            gp1_q       <= gp1_d;
            gp2_q       <= gp2_d;
            clr_q       <= clr_d;
            rp_q        <= rp_d;
`ifdef MATCH_TIMER_EN
            time_left_q <= time_left_d;
            sec_cnt_q   <= sec_cnt_d;
`endif
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        gp1_d    = 1'b0;
        gp2_d    = 1'b0;
        clr_d    = 1'b0;
        rp_d     = 1'b0;
`ifdef MATCH_TIMER_EN
        time_left_d = time_left_q;
        sec_cnt_d   = sec_cnt_q;
`endif

        unique case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_btn) begin
                    state_d  = S_KICKOFF;
                    score1_d = '0;
                    score2_d = '0;
                    winner_d = 2'b00;
                    clr_d    = 1'b1;
                    rp_d     = 1'b1;
`ifdef MATCH_TIMER_EN
                    time_left_d = 8'(MATCH_SECONDS);
                    sec_cnt_d   = '0;
`endif
                end
            end
            S_KICKOFF: begin
                if (frame_tick && frame_cnt_q == KICK_LAST) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (rise1) begin
                    gp1_d    = 1'b1;
                    score1_d = sat_inc(score1_q);
                    state_d  = S_GOAL;
                end else if (rise2) begin
                    gp2_d    = 1'b1;
                    score2_d = sat_inc(score2_q);
                    state_d  = S_GOAL;
`ifdef MATCH_TIMER_EN
                end else if (time_left_q == 8'd0) begin
                    state_d = S_GAME_OVER;
                    if (score1_q > score2_q)      winner_d = 2'b01;
                    else if (score2_q > score1_q) winner_d = 2'b10;
                    else                          winner_d = 2'b11;
`endif
                end else if (pause_btn) begin
                    state_d = S_PAUSED;
`ifdef MATCH_TIMER_EN
                end else if (frame_tick) begin
                    if (sec_cnt_q == SEC_LAST) begin
                        sec_cnt_d   = '0;
                        time_left_d = time_left_q - 8'd1;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 16'd1;
                    end
`endif
                end
            end
            S_GOAL: begin
                if (frame_tick && frame_cnt_q == GOAL_LAST) begin
                    if (score1_q == WIN || score2_q == WIN) begin
                        state_d  = S_GAME_OVER;
                        winner_d = (score1_q == WIN) ? 2'b01 : 2'b10;
                    end else begin
                        rp_d    = 1'b1;
                        state_d = S_KICKOFF;
                    end
                end
            end
            S_PAUSED: begin
                if (pause_btn) begin
                    state_d = S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Phase frame counter runs only in the timed phases and restarts on every state change.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end else if (frame_tick && (state_q == S_KICKOFF || state_q == S_GOAL)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_comb begin
        state           = state_q;
        freeze          = (state_q != S_PLAY);
        goal_player1    = gp1_q;
        goal_player2    = gp2_q;
        clear_scores    = clr_q;
        reset_positions = rp_q;
        winner          = winner_q;
`ifdef MATCH_TIMER_EN
        time_left       = time_left_q;
`else
        time_left       = 8'd0;
`endif
    end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: start/kickoff, goal edges, wins, pause, reset and match timer.
module tb_match_controller;

    localparam int WIN  = 2;
    localparam int FPS  = 4;
    localparam int SECS = 2;
    localparam int KO   = 120;
    localparam int GF   = 180;
`ifdef MATCH_TIMER_EN
    localparam logic [7:0] TL_START = 8'(SECS);
`else
    localparam logic [7:0] TL_START = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       ball_in_goal1 = 1'b0;
    logic       ball_in_goal2 = 1'b0;
    logic       goal_player1, goal_player2, clear_scores, reset_positions, freeze;
    logic [2:0] state;
    logic [1:0] winner;
    logic [7:0] time_left;

    int n_checks = 0;
    int n_fail   = 0;
    int gp1_cnt = 0, gp2_cnt = 0, clr_cnt = 0, rp_cnt = 0;

    match_controller #(
        .WIN_SCORE(WIN), .KICKOFF_FRAMES(KO), .GOAL_FRAMES(GF),
        .FRAMES_PER_SEC(FPS), .MATCH_SECONDS(SECS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .start_btn(start_btn), .pause_btn(pause_btn),
        .ball_in_goal1(ball_in_goal1), .ball_in_goal2(ball_in_goal2),
        .goal_player1(goal_player1), .goal_player2(goal_player2),
        .clear_scores(clear_scores), .reset_positions(reset_positions),
        .freeze(freeze), .state(state), .winner(winner), .time_left(time_left)
    );

    always #5 clk = ~clk;

    // Pulse tallies, sampled on the falling edge.
    always @(negedge clk) begin
        if (goal_player1)    gp1_cnt++;
        if (goal_player2)    gp2_cnt++;
        if (clear_scores)    clr_cnt++;
        if (reset_positions) rp_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run still active at %0t, limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; step();
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1; step(); start_btn = 1'b0;
    endtask

    task automatic press_pause();
        pause_btn = 1'b1; step(); pause_btn = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
        n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL rst_freeze: got %b want 1", freeze); end
        n_checks++; if ({goal_player1, goal_player2, clear_scores, reset_positions} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_pulses: got %b want 0000", {goal_player1, goal_player2, clear_scores, reset_positions}); end
        n_checks++; if (winner !== 2'b00) begin n_fail++; $display("FAIL rst_winner: got %b want 00", winner); end
        n_checks++; if (time_left !== 8'd0) begin n_fail++; $display("FAIL rst_time: got %0d want 0", time_left); end
        reset_n = 1'b1;
        step();
        press_pause(); step();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL idle_pause_ignored: got %0d want 0", state); end
    endtask

    task automatic test_start();
        int c0;
        int r0;
        c0 = clr_cnt; r0 = rp_cnt;
        press_start();
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", state); end
        n_checks++; if (clear_scores !== 1'b1) begin n_fail++; $display("FAIL start_clear: got %b want 1", clear_scores); end
        n_checks++; if (reset_positions !== 1'b1) begin n_fail++; $display("FAIL start_respawn: got %b want 1", reset_positions); end
        n_checks++; if (time_left !== TL_START) begin n_fail++; $display("FAIL start_time: got %0d want %0d", time_left, TL_START); end
        step();
        n_checks++; if ({clear_scores, reset_positions} !== 2'b00) begin
            n_fail++; $display("FAIL start_pulse_width: got %b want 00", {clear_scores, reset_positions}); end
        press_pause(); step();
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL kick_pause_ignored: got %0d want 1", state); end
        tick(KO - 1);
        n_checks++; if (state !== 3'd1 || freeze !== 1'b1) begin
            n_fail++; $display("FAIL kick_hold: got state %0d freeze %b want 1/1", state, freeze); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL kick_to_play: got %0d want 2", state); end
        n_checks++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL play_freeze: got %b want 0", freeze); end
        step();
        n_checks++; if (clr_cnt - c0 !== 1 || rp_cnt - r0 !== 1) begin
            n_fail++; $display("FAIL start_pulse_count: got clr %0d rp %0d want 1/1", clr_cnt - c0, rp_cnt - r0); end
    endtask

    task automatic test_goal_hold();
        int g0;
        int r0;
        g0 = gp1_cnt; r0 = rp_cnt;
        ball_in_goal1 = 1'b1; step();
        n_checks++; if (goal_player1 !== 1'b1) begin n_fail++; $display("FAIL hold_goal_pulse: got %b want 1", goal_player1); end
        n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL hold_goal_state: got %0d want 3", state); end
        tick(GF - 1);
        n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL goal_phase_hold: got %0d want 3", state); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        n_checks++; if (state !== 3'd1 || reset_positions !== 1'b1) begin
            n_fail++; $display("FAIL goal_to_kick: got state %0d rp %b want 1/1", state, reset_positions); end
        step();
        tick(KO);
        repeat (10) step();
        n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL hold_back_to_play: got %0d want 2", state); end
        n_checks++; if (gp1_cnt - g0 !== 1) begin n_fail++; $display("FAIL hold_single_goal: got %0d pulses want 1", gp1_cnt - g0); end
        n_checks++; if (rp_cnt - r0 !== 1) begin n_fail++; $display("FAIL hold_respawn_count: got %0d want 1", rp_cnt - r0); end
        ball_in_goal1 = 1'b0; step();
    endtask

    task automatic test_simultaneous();
        int g1;
        int g2;
        g1 = gp1_cnt; g2 = gp2_cnt;
        ball_in_goal1 = 1'b1; ball_in_goal2 = 1'b1; step();
        n_checks++; if ({goal_player1, goal_player2} !== 2'b10) begin
            n_fail++; $display("FAIL simul_goal: got p1 %b p2 %b want 1/0", goal_player1, goal_player2); end
        n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL simul_state: got %0d want 3", state); end
        ball_in_goal1 = 1'b0; ball_in_goal2 = 1'b0;
        tick(GF);
        n_checks++; if (state !== 3'd5 || winner !== 2'b01) begin
            n_fail++; $display("FAIL p1_win: got state %0d winner %b want 5/01", state, winner); end
        n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL over_freeze: got %b want 1", freeze); end
        n_checks++; if (gp1_cnt - g1 !== 1 || gp2_cnt - g2 !== 0) begin
            n_fail++; $display("FAIL simul_counts: got p1 %0d p2 %0d want 1/0", gp1_cnt - g1, gp2_cnt - g2); end
    endtask

    task automatic test_win_p2();
        int c0;
        press_start();
        n_checks++; if (clear_scores !== 1'b1 || state !== 3'd1 || winner !== 2'b00) begin
            n_fail++; $display("FAIL restart1: got clr %b state %0d winner %b want 1/1/00", clear_scores, state, winner); end
        step();
        tick(KO);
        ball_in_goal2 = 1'b1; step();
        n_checks++; if (goal_player2 !== 1'b1 || state !== 3'd3) begin
            n_fail++; $display("FAIL p2_goal1: got pulse %b state %0d want 1/3", goal_player2, state); end
        ball_in_goal2 = 1'b0;
        tick(GF);
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL p2_goal1_kick: got %0d want 1", state); end
        tick(KO);
        c0 = clr_cnt;
        press_start(); step();
        n_checks++; if (state !== 3'd2 || clr_cnt !== c0) begin
            n_fail++; $display("FAIL play_start_ignored: got state %0d clr %0d want 2/0", state, clr_cnt - c0); end
        ball_in_goal2 = 1'b1; step();
        n_checks++; if (goal_player2 !== 1'b1) begin n_fail++; $display("FAIL p2_goal2: got %b want 1", goal_player2); end
        ball_in_goal2 = 1'b0;
        tick(GF);
        n_checks++; if (state !== 3'd5 || winner !== 2'b10) begin
            n_fail++; $display("FAIL p2_win: got state %0d winner %b want 5/10", state, winner); end
        press_start();
        n_checks++; if (clear_scores !== 1'b1 || state !== 3'd1 || winner !== 2'b00) begin
            n_fail++; $display("FAIL restart2: got clr %b state %0d winner %b want 1/1/00", clear_scores, state, winner); end
        step();
    endtask

    task automatic test_pause();
        tick(KO);
        press_pause();
        n_checks++; if (state !== 3'd4 || freeze !== 1'b1) begin
            n_fail++; $display("FAIL pause_enter: got state %0d freeze %b want 4/1", state, freeze); end
        tick(3);
        ball_in_goal1 = 1'b1; step();
        n_checks++; if (goal_player1 !== 1'b0 || state !== 3'd4) begin
            n_fail++; $display("FAIL paused_goal_ignored: got pulse %b state %0d want 0/4", goal_player1, state); end
        n_checks++; if (time_left !== TL_START) begin n_fail++; $display("FAIL paused_time: got %0d want %0d", time_left, TL_START); end
        press_pause();
        n_checks++; if (state !== 3'd2 || freeze !== 1'b0) begin
            n_fail++; $display("FAIL pause_exit: got state %0d freeze %b want 2/0", state, freeze); end
        step();
        n_checks++; if (goal_player1 !== 1'b0 || state !== 3'd2) begin
            n_fail++; $display("FAIL resume_no_retrigger: got pulse %b state %0d want 0/2", goal_player1, state); end
        ball_in_goal1 = 1'b0; step();
        ball_in_goal1 = 1'b1; step();
        n_checks++; if (goal_player1 !== 1'b1 || state !== 3'd3) begin
            n_fail++; $display("FAIL resume_goal: got pulse %b state %0d want 1/3", goal_player1, state); end
        ball_in_goal1 = 1'b0;
        tick(GF);
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL scores_cleared: got %0d want 1", state); end
    endtask

    task automatic test_reset_mid_goal();
        tick(KO);
        ball_in_goal2 = 1'b1; step();
        n_checks++; if (state !== 3'd3 || goal_player2 !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_goal: got state %0d pulse %b want 3/1", state, goal_player2); end
        reset_n = 1'b0; #1;
        n_checks++; if (state !== 3'd0 || freeze !== 1'b1 || goal_player2 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got state %0d freeze %b gp2 %b want 0/1/0", state, freeze, goal_player2); end
        n_checks++; if (winner !== 2'b00 || time_left !== 8'd0 || clear_scores !== 1'b0 || reset_positions !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_out: got winner %b time %0d clr %b rp %b want 00/0/0/0",
                               winner, time_left, clear_scores, reset_positions); end
        ball_in_goal2 = 1'b0;
        step();
        reset_n = 1'b1;
        step(); step();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL post_reset_idle: got %0d want 0", state); end
        press_start();
        n_checks++; if (state !== 3'd1 || clear_scores !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_start: got state %0d clr %b want 1/1", state, clear_scores); end
        step();
    endtask

`ifdef MATCH_TIMER_EN
    task automatic test_timer();
        tick(KO);
        n_checks++; if (state !== 3'd2 || time_left !== 8'd2) begin
            n_fail++; $display("FAIL timer_start: got state %0d time %0d want 2/2", state, time_left); end
        tick(FPS + 2);
        n_checks++; if (time_left !== 8'd1) begin n_fail++; $display("FAIL timer_one_sec: got %0d want 1", time_left); end
        press_pause();
        tick(20);
        n_checks++; if (time_left !== 8'd1 || state !== 3'd4) begin
            n_fail++; $display("FAIL timer_paused: got time %0d state %0d want 1/4", time_left, state); end
        press_pause();
        tick(1);
        n_checks++; if (time_left !== 8'd1 || state !== 3'd2) begin
            n_fail++; $display("FAIL timer_resume: got time %0d state %0d want 1/2", time_left, state); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        n_checks++; if (time_left !== 8'd0 || state !== 3'd2) begin
            n_fail++; $display("FAIL timer_zero: got time %0d state %0d want 0/2", time_left, state); end
        step();
        n_checks++; if (state !== 3'd5 || winner !== 2'b11) begin
            n_fail++; $display("FAIL timer_draw: got state %0d winner %b want 5/11", state, winner); end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_goal_hold();
        test_simultaneous();
        test_win_p2();
        test_pause();
        test_reset_mid_goal();
`ifdef MATCH_TIMER_EN
        test_timer();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
